// File: rtl/minisys_pkg.sv
// Shared encodings for the Minisys writeback stage.
package minisys_pkg;

  // Load size encoding carried with every memory-stage instruction.
  // The unused code 2'b11 behaves as a word load.
  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  // Register that receives the return address on jal/jalr.
  localparam int LINK_REG_DEFAULT = 31;

  // True when an access of the given size cannot be served from the
  // addressed lane without crossing a naturally aligned boundary.
  function automatic logic load_is_misaligned(input logic [1:0] size,
                                              input logic [1:0] addr_low);
    logic mis;
    mis = 1'b0;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = addr_low[0];
      default: mis = (addr_low != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/minisys_wb_stage_load_ext.sv
// Little-endian sub-word load extraction and alignment check.
// Purely combinational: raw memory word in, register-ready value out.
module minisys_load_ext
  import minisys_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr_low,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_sign;
  logic        w_half_sign;

  // Pick the addressed byte lane and half-word lane.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_low)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_low[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension fill bit is zero for unsigned loads, otherwise the lane MSB.
  assign w_byte_sign = ~i_unsigned & w_byte[7];
  assign w_half_sign = ~i_unsigned & w_half[15];

  // Size mux; word (and the reserved code) pass the raw word through.
  always_comb begin
    o_data = i_word;
    case (i_size)
      LS_BYTE: o_data = {{(DATA_W-8){w_byte_sign}}, w_byte};
      LS_HALF: o_data = {{(DATA_W-16){w_half_sign}}, w_half};
      default: o_data = i_word;
    endcase
  end

  assign o_misalign = load_is_misaligned(i_size, i_addr_low);

endmodule

// File: rtl/minisys_wb_stage.sv
// Minisys writeback stage: MEM/WB pipeline register, register-file write
// port, one-deep post-writeback bypass register and retirement counter.
//
// Pipeline control: stallW holds every register in this stage; flushW
// replaces the WB entry with an all-zero bubble and wins over stallW for
// the WB register only. The bypass register and counter always obey
// stallW as driven, so a flush+stall edge leaves them untouched.
module minisys_wb_stage
  import minisys_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              stallW,
  input  logic              flushW,
  input  logic              valid_M,
  input  logic              reg_write_M,
  input  logic              mem2reg_M,
  input  logic              link_M,
  input  logic [1:0]        load_size_M,
  input  logic              load_unsigned_M,
  input  logic [1:0]        addr_low_M,
  input  logic [DATA_W-1:0] alu_out_M,
  input  logic [DATA_W-1:0] read_data_M,
  input  logic [DATA_W-1:0] pcplus4_M,
  input  logic [REG_AW-1:0] write_reg_M,
  output logic              valid_W,
  output logic              reg_write_W,
  output logic [REG_AW-1:0] write_reg_W,
  output logic [DATA_W-1:0] result_W,
  output logic              load_misalign_W,
  output logic              byp_we_D,
  output logic [REG_AW-1:0] byp_reg_D,
  output logic [DATA_W-1:0] byp_data_D,
  output logic [CNT_W-1:0]  retired_cnt
);

  // MEM/WB register fields; raw memory data is kept so extraction happens
  // after the register and the WB outputs stay a pure function of it.
  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem2reg;
  logic              r_link;
  logic [1:0]        r_load_size;
  logic              r_load_unsigned;
  logic [1:0]        r_addr_low;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] r_read_data;
  logic [DATA_W-1:0] r_pcplus4;
  logic [REG_AW-1:0] r_write_reg;

  logic              r_byp_we;
  logic [REG_AW-1:0] r_byp_reg;
  logic [DATA_W-1:0] r_byp_data;
  logic [CNT_W-1:0]  r_retired_cnt;

  logic [DATA_W-1:0] w_load_data;
  logic              w_load_misalign_raw;
  logic              w_misalign;
  logic [REG_AW-1:0] w_dest;
  logic [DATA_W-1:0] w_result;
  logic              w_we;

  // WB register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid         <= 1'b0;
      r_reg_write     <= 1'b0;
      r_mem2reg       <= 1'b0;
      r_link          <= 1'b0;
      r_load_size     <= 2'b00;
      r_load_unsigned <= 1'b0;
      r_addr_low      <= 2'b00;
      r_alu_out       <= '0;
      r_read_data     <= '0;
      r_pcplus4       <= '0;
      r_write_reg     <= '0;
    end else if (flushW) begin
      r_valid         <= 1'b0;
      r_reg_write     <= 1'b0;
      r_mem2reg       <= 1'b0;
      r_link          <= 1'b0;
      r_load_size     <= 2'b00;
      r_load_unsigned <= 1'b0;
      r_addr_low      <= 2'b00;
      r_alu_out       <= '0;
      r_read_data     <= '0;
      r_pcplus4       <= '0;
      r_write_reg     <= '0;
    end else if (!stallW) begin
      r_valid         <= valid_M;
      r_reg_write     <= reg_write_M;
      r_mem2reg       <= mem2reg_M;
      r_link          <= link_M;
      r_load_size     <= load_size_M;
      r_load_unsigned <= load_unsigned_M;
      r_addr_low      <= addr_low_M;
      r_alu_out       <= alu_out_M;
      r_read_data     <= read_data_M;
      r_pcplus4       <= pcplus4_M;
      r_write_reg     <= write_reg_M;
    end
  end

  minisys_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .i_word    (r_read_data),
    .i_addr_low(r_addr_low),
    .i_size    (r_load_size),
    .i_unsigned(r_load_unsigned),
    .o_data    (w_load_data),
    .o_misalign(w_load_misalign_raw)
  );

  // Result select: link beats load data, load data beats the ALU result.
  always_comb begin
    w_dest   = r_write_reg;
    w_result = r_alu_out;
    if (r_link) begin
      w_dest   = REG_AW'(LINK_REG);
      w_result = r_pcplus4;
    end else if (r_mem2reg) begin
      w_result = w_load_data;
    end
  end

  // Misalignment only matters for a real load whose value is used;
  // a suppressed write still retires.
  assign w_misalign = r_valid & r_mem2reg & ~r_link & w_load_misalign_raw;
  assign w_we       = r_valid & r_reg_write & ~w_misalign & (w_dest != '0);

  // Bypass register: snapshot of the outgoing write on every unstalled edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_byp_we   <= 1'b0;
      r_byp_reg  <= '0;
      r_byp_data <= '0;
    end else if (!stallW) begin
      r_byp_we   <= w_we;
      r_byp_reg  <= w_dest;
      r_byp_data <= w_result;
    end
  end

  // Retirement counter: a valid entry retires when it leaves unstalled.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_retired_cnt <= '0;
    end else if (r_valid && !stallW) begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign valid_W         = r_valid;
  assign reg_write_W     = w_we;
  assign write_reg_W     = w_dest;
  assign result_W        = w_result;
  assign load_misalign_W = w_misalign;
  assign byp_we_D        = r_byp_we;
  assign byp_reg_D       = r_byp_reg;
  assign byp_data_D      = r_byp_data;
  assign retired_cnt     = r_retired_cnt;

endmodule

// File: doc/minisys_wb_stage.md
# minisys_wb_stage

Parametrised writeback stage for the Minisys pipelined CPU. Owns the MEM/WB pipeline register and produces the register-file write port: address, data and enable. It also provides sub-word load extraction, link-register writes, misaligned-load suppression, a one-deep post-writeback bypass register for the decode stage, and a retired-instruction counter. It sits between the memory stage and the register file / hazard unit.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- LINK_REG, 31, destination register for link writes
- CNT_W, 32, retired-instruction counter width

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state updates on the rising edge
  - clrn  in  1  asynchronous active-low reset
- stallW  in  1  hold the WB register contents
- flushW  in  1  load a bubble into the WB register
- valid_M  in  1  memory-stage slot holds a real instruction
- reg_write_M  in  1  instruction writes a GPR
- mem2reg_M  in  1  result comes from load data
- link_M  in  1  jal/jalr-style link write
- load_size_M  in  2  load size: byte, half or word (encodings in package)
- load_unsigned_M  in  1  zero-extend sub-word loads
- addr_low_M  in  2  byte address bits [1:0] of the load
- alu_out_M  in  DATA_W  ALU result
- read_data_M  in  DATA_W  raw memory word
- pcplus4_M  in  DATA_W  link value
- write_reg_M  in  REG_AW  destination register
- valid_W  out  1  WB slot holds a real instruction
- reg_write_W  out  1  register-file write enable
- write_reg_W  out  REG_AW  register-file write address
- result_W  out  DATA_W  register-file write data
- load_misalign_W  out  1  misaligned load in WB; its write is suppressed
- byp_we_D  out  1  bypass: the previous WB write was valid
- byp_reg_D  out  REG_AW  bypass address
- byp_data_D  out  DATA_W  bypass data
- retired_cnt  out  CNT_W  count of retired instructions

## Operation
- **WB register update.** On each clk edge, priority is:
  - flushW=1: load a bubble (all fields 0).
  - else stallW=1: hold the current contents.
  - else: capture all *_M inputs.
- **Result select.** Priority is link_M, then mem2reg_M, then the ALU result:
  - link: write_reg_W=LINK_REG and result_W=pcplus4.
  - else mem2reg: result_W is the extended load data.
  - else: result_W is alu_out.
- **Load extraction (little-endian).**
  - Byte: lane = addr_low.
  - Half: lane = addr_low[1].
  - Word: the full word.
  - Sub-word results are sign-extended unless load_unsigned is set.
- **Misalignment.**
  - A half load with addr_low[0]=1 is misaligned.
  - A word load with addr_low≠0 is misaligned.
  - load_misalign_W is set only when the entry is valid, mem2reg=1 and link=0.
- **Write enable.** reg_write_W = valid & reg_write & ~load_misalign_W & (write_reg_W≠0).
- **Bypass register.** On every edge with stallW=0, it captures the current {reg_write_W, write_reg_W, result_W}. It holds when stallW=1. It is not affected by flushW.
- **Retirement counter.** retired_cnt increments on every edge where valid_W=1 and stallW=0. This includes suppressed (misaligned) instructions. It wraps modulo 2^CNT_W.

## Timing
- Latency is 1 cycle from the *_M inputs to the WB outputs. The WB outputs are combinational from the WB register.
- Reset: every register clears to 0 asynchronously. After reset all outputs are 0 (valid_W, reg_write_W, result_W, byp_*, retired_cnt, load_misalign_W).
- Reset mid-stall clears the stall-held entry. The first edge after reset release samples normally.
- flushW and stallW together: flush wins. The bubble is inserted and the counter counts the departing valid entry (because stallW is treated as overridden only for the WB register).
  - Correction to the above: the counter and bypass register see stallW as given. With flush+stall they hold.
- Stall: a held entry keeps reg_write_W asserted. The repeated write is idempotent.
- A write to register 0 never asserts reg_write_W. Such an instruction still counts as retired.

## Structure
- Package minisys_pkg holds:
  - LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10 (2'b11 is treated as word)
  - LINK_REG_DEFAULT=31
- Sub-module minisys_load_ext: combinational (raw word, addr_low, size, unsigned) → extended data and misalign flag.
- Everything else stays in minisys_wb_stage: the WB register, result mux, bypass register and counter.

## Test plan
1. **Reset.** Assert clrn=0 mid-run. Expect all outputs to be 0 immediately; retired_cnt=0.
2. **Byte and half loads.** read_data=0x80FF_7F01:
   - signed byte, addr_low=2 → result 0xFFFF_FFFF
   - signed byte, addr_low=3 → result 0xFFFF_FF80
   - unsigned half, addr_low=2 → result 0x0000_80FF
   - signed half, addr_low=0 → result 0x0000_7F01
3. **Link write.** link=1, mem2reg=1, write_reg=5, pcplus4=0x0040_0008. Expect write_reg_W=31, result=0x0040_0008, reg_write_W=1.
4. **Misaligned load.** Word load with addr_low=1. Expect load_misalign_W=1 and reg_write_W=0. retired_cnt still increments by 1.
5. **Stall then flush.** Enter instr A, stall for 2 cycles, then flush with stall low:
   - WB holds A for 3 cycles.
   - retired_cnt increases by exactly 1 when A leaves.
   - The bypass register shows A after the un-stalled edge.
   - Then a bubble appears with reg_write_W=0.
6. **$zero and wrap.** write_reg=0 with reg_write=1 → reg_write_W=0. With CNT_W=4, 17 retirements → retired_cnt=1.
